// File: rtl/hamming_secded_decoder.sv
// ============================================================================
// hamming_secded_decoder : extended Hamming (8,4) SECDED decoder, 2-stage pipe
//                          with saturating error counters and health FSM.
// Revision 1.0
// ============================================================================
`default_nettype none

module hamming_secded_decoder #(
  parameter int CNT_W       = 8,
  parameter int CORR_THRESH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [7:0]       in_code,
  input  logic             clr_stats,
  output logic             out_valid,
  output logic [3:0]       out_data,
  output logic             out_single,
  output logic             out_double,
  output logic [2:0]       out_err_pos,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double,
  output logic [1:0]       health
);

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_DEGRADED = 2'd1,
    ST_FAILED   = 2'd2
  } health_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_THRESH  = CNT_W'(CORR_THRESH);

  // Stage 1 registers
  logic       s1_valid_q;
  logic [7:0] s1_code_q;
  logic [2:0] s1_syn_q;
  logic       s1_par_q;
  logic [2:0] syn_d;
  logic       par_d;

  // Stage 2 / statistics registers
  logic             out_valid_q;
  logic [3:0]       out_data_q;
  logic             out_single_q;
  logic             out_double_q;
  logic [2:0]       out_err_pos_q;
  logic [CNT_W-1:0] cnt_single_q, cnt_single_d;
  logic [CNT_W-1:0] cnt_double_q, cnt_double_d;
  health_t          health_q, health_d;

  // Classification of the stage-1 word
  logic       cls_single;
  logic       cls_double;
  logic [2:0] cls_pos;
  logic [3:0] cls_data;
  logic [7:0] flip;
  logic [7:0] fixed;

  always_comb begin
    syn_d[0] = in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6];
    syn_d[1] = in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6];
    syn_d[2] = in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6];
    par_d    = ^in_code;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      s1_code_q  <= in_code;
      s1_syn_q   <= syn_d;
      s1_par_q   <= par_d;
    end
  end

  always_comb begin
    cls_single = 1'b0;
    cls_double = 1'b0;
    cls_pos    = '0;
    flip       = '0;
    if (s1_valid_q) begin
      if (s1_syn_q != 3'd0 && s1_par_q) begin
        cls_single    = 1'b1;
        cls_pos       = s1_syn_q - 3'd1;
        flip[cls_pos] = 1'b1;
      end else if (s1_syn_q == 3'd0 && s1_par_q) begin
        // Only the overall parity bit is wrong; data is already good.
        cls_single = 1'b1;
        cls_pos    = 3'd7;
      end else if (s1_syn_q != 3'd0) begin
        cls_double = 1'b1;
      end
    end
    fixed    = s1_code_q ^ flip;
    cls_data = s1_valid_q ? {fixed[6], fixed[5], fixed[4], fixed[2]} : 4'd0;
  end

  always_comb begin
    cnt_single_d = cnt_single_q;
    cnt_double_d = cnt_double_q;
    health_d     = health_q;
    if (clr_stats) begin
      cnt_single_d = '0;
      cnt_double_d = '0;
      health_d     = ST_OK;
    end else begin
      if (cls_single && cnt_single_q != C_CNT_MAX) cnt_single_d = cnt_single_q + 1'b1;
      if (cls_double && cnt_double_q != C_CNT_MAX) cnt_double_d = cnt_double_q + 1'b1;
      case (health_q)
        ST_OK: begin
          if (cls_double)
            health_d = ST_FAILED;
          else if (cls_single && cnt_single_d >= C_THRESH)
            health_d = ST_DEGRADED;
        end
        ST_DEGRADED: if (cls_double) health_d = ST_FAILED;
        ST_FAILED:   health_d = ST_FAILED;
        default:     health_d = ST_OK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_single_q  <= 1'b0;
      out_double_q  <= 1'b0;
      out_err_pos_q <= '0;
      cnt_single_q  <= '0;
      cnt_double_q  <= '0;
      health_q      <= ST_OK;
    end else begin
      out_valid_q   <= s1_valid_q;
      out_data_q    <= cls_data;
      out_single_q  <= cls_single;
      out_double_q  <= cls_double;
      out_err_pos_q <= cls_pos;
      cnt_single_q  <= cnt_single_d;
      cnt_double_q  <= cnt_double_d;
      health_q      <= health_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_single  = out_single_q;
  assign out_double  = out_double_q;
  assign out_err_pos = out_err_pos_q;
  assign cnt_single  = cnt_single_q;
  assign cnt_double  = cnt_double_q;
  assign health      = health_q;

endmodule

`default_nettype wire

// File: tb/tb_hamming_secded_decoder.sv
// ============================================================================
// tb_hamming_secded_decoder : directed self-checking bench for the decoder,
//                             default instance plus a CNT_W=2 instance.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_hamming_secded_decoder;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_code = 8'h00;
  logic       clr_stats = 1'b0;

  logic       out_valid, out_single, out_double;
  logic [3:0] out_data;
  logic [2:0] out_err_pos;
  logic [7:0] cnt_single, cnt_double;
  logic [1:0] health;

  logic       w2_out_valid, w2_out_single, w2_out_double;
  logic [3:0] w2_out_data;
  logic [2:0] w2_out_err_pos;
  logic [1:0] w2_cnt_single, w2_cnt_double;
  logic [1:0] w2_health;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hamming_secded_decoder #(.CNT_W(8), .CORR_THRESH(4)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_code(in_code),
    .clr_stats(clr_stats), .out_valid(out_valid), .out_data(out_data),
    .out_single(out_single), .out_double(out_double), .out_err_pos(out_err_pos),
    .cnt_single(cnt_single), .cnt_double(cnt_double), .health(health)
  );

  hamming_secded_decoder #(.CNT_W(2), .CORR_THRESH(3)) u_dut_w2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_code(in_code),
    .clr_stats(clr_stats), .out_valid(w2_out_valid), .out_data(w2_out_data),
    .out_single(w2_out_single), .out_double(w2_out_double),
    .out_err_pos(w2_out_err_pos), .cnt_single(w2_cnt_single),
    .cnt_double(w2_cnt_double), .health(w2_health)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic v, input logic [3:0] d,
                         input logic s, input logic db, input logic [2:0] p,
                         input logic [7:0] cs, input logic [7:0] cd, input logic [1:0] h);
    chk({tag, ".valid"},  32'(out_valid),   32'(v));
    chk({tag, ".data"},   32'(out_data),    32'(d));
    chk({tag, ".single"}, 32'(out_single),  32'(s));
    chk({tag, ".double"}, 32'(out_double),  32'(db));
    chk({tag, ".pos"},    32'(out_err_pos), 32'(p));
    chk({tag, ".cnt_s"},  32'(cnt_single),  32'(cs));
    chk({tag, ".cnt_d"},  32'(cnt_double),  32'(cd));
    chk({tag, ".health"}, 32'(health),      32'(h));
  endtask

  // Single-cycle word: present, then look at the output two edges later.
  task automatic send(input logic [7:0] code);
    in_valid = 1'b1;
    in_code  = code;
    step();
    in_valid = 1'b0;
    chk("latency.early", 32'(out_valid), 32'd0);
    step();
  endtask

  logic [7:0] stream [4] = '{8'h54, 8'h45, 8'hD5, 8'h57};
  logic [3:0] stream_pos [4] = '{4'd0, 4'd4, 4'd7, 4'd1};
  logic [1:0] w2_cnt_exp [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
  logic [1:0] w2_h_exp   [4] = '{2'd0, 2'd0, 2'd1, 2'd1};

  initial begin
    // Reset state
    step();
    exp_out("reset", 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 2'd0);
    chk("reset.w2_cnt", 32'(w2_cnt_single), 32'd0);
    rstn = 1'b1;
    step();

    // Clean word
    send(8'h55);
    exp_out("clean", 1'b1, 4'hB, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 2'd0);
    step();
    exp_out("idle", 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 2'd0);

    send(8'h54);
    exp_out("bit0", 1'b1, 4'hB, 1'b1, 1'b0, 3'd0, 8'd1, 8'd0, 2'd0);
    send(8'h45);
    exp_out("bit4", 1'b1, 4'hB, 1'b1, 1'b0, 3'd4, 8'd2, 8'd0, 2'd0);
    send(8'hD5);
    exp_out("p0", 1'b1, 4'hB, 1'b1, 1'b0, 3'd7, 8'd3, 8'd0, 2'd0);
    send(8'h44);
    exp_out("double", 1'b1, 4'h9, 1'b0, 1'b1, 3'd0, 8'd3, 8'd1, 2'd2);
    step();
    exp_out("failed_sticky", 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 8'd3, 8'd1, 2'd2);

    // Clear statistics with the pipeline empty
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    exp_out("clr", 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 2'd0);
    chk("clr.w2_cnt", 32'(w2_cnt_single), 32'd0);

    // Back-to-back stream of four single-error words
    in_valid = 1'b1;
    in_code  = stream[0];
    step();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) in_code = stream[i+1];
      else in_valid = 1'b0;
      step();
      exp_out($sformatf("stream%0d", i), 1'b1, 4'hB, 1'b1, 1'b0, stream_pos[i][2:0],
              8'(i + 1), 8'd0, (i == 3) ? 2'd1 : 2'd0);
      chk($sformatf("stream%0d.w2_cnt", i), 32'(w2_cnt_single), 32'(w2_cnt_exp[i]));
      chk($sformatf("stream%0d.w2_health", i), 32'(w2_health), 32'(w2_h_exp[i]));
    end
    step();
    chk("stream.gap", 32'(out_valid), 32'd0);

    // Fifth error: narrow counter stays saturated
    send(8'h54);
    exp_out("fifth", 1'b1, 4'hB, 1'b1, 1'b0, 3'd0, 8'd5, 8'd0, 2'd1);
    chk("fifth.w2_sat", 32'(w2_cnt_single), 32'd3);

    // clr_stats in the cycle the double error sits in stage 1
    in_valid = 1'b1;
    in_code  = 8'h44;
    step();
    in_valid  = 1'b0;
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    exp_out("clr_vs_double", 1'b1, 4'h9, 1'b0, 1'b1, 3'd0, 8'd0, 8'd0, 2'd0);
    chk("clr_vs_double.w2_health", 32'(w2_health), 32'd0);

    // Asynchronous reset with words in flight
    in_valid = 1'b1;
    in_code  = 8'h55;
    step();
    in_code = 8'h54;
    step();
    chk("pre_rst.valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    exp_out("async_rst", 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 2'd0);
    step();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst%0d.valid", i), 32'(out_valid), 32'd0);
    end

    send(8'h57);
    exp_out("recover", 1'b1, 4'hB, 1'b1, 1'b0, 3'd1, 8'd1, 8'd0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
